fsmc_slave_dispatcher: RTL and testbench

Bus-side controller that sits directly behind `fsmc_interface` and shares the single FSMC data path between up to eight on-chip slave register blocks. It decodes the latched chip-select index into a one-hot slave select and prefetches read data so `module_out` is ready before NOE data drive. It forwards captured write data as a single-cycle write strobe, runs a request/acknowledge handshake per access, and drives `cs_state` back to the interface.

---
 rtl/fsmc_slave_dispatcher_if.sv | 42 ++++
 rtl/fsmc_slave_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fsmc_slave_dispatcher.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_slave_dispatcher_if.sv
// -----------------------------------------------------------------------------
// fsmc_slave_dispatcher_if
// Slave-side register bus between fsmc_slave_dispatcher and up to NSLV
// on-chip slave register blocks.
//
// Handshake: the dispatcher raises slv_sel[i] for the whole access and pulses
// slv_rd or slv_wr for exactly one cycle. Slave i completes the request by
// asserting slv_ack[i] (sampled on a rising clk edge) in that same cycle or
// any later one. Read data on slv_rdata[16i+15:16i] is sampled on the ack edge.
// Only the ack of the selected slave is looked at.
//
// Signals:
//   slv_sel   dispatcher -> slaves  one-hot select
//   slv_addr  dispatcher -> slaves  latched slave address
//   slv_wdata dispatcher -> slaves  latched write data
//   slv_rd    dispatcher -> slaves  1-cycle read request
//   slv_wr    dispatcher -> slaves  1-cycle write request
//   slv_rdata slaves -> dispatcher  packed read data, 16 bits per slave
//   slv_ack   slaves -> dispatcher  per-slave request completion
// -----------------------------------------------------------------------------
interface fsmc_slave_dispatcher_if #(
  parameter int NSLV   = 8,
  parameter int ADDR_W = 15
);
  logic [NSLV-1:0]      slv_sel;
  logic [ADDR_W-1:0]    slv_addr;
  logic [15:0]          slv_wdata;
  logic                 slv_rd;
  logic                 slv_wr;
  logic [16*NSLV-1:0]   slv_rdata;
  logic [NSLV-1:0]      slv_ack;

  modport master (
    output slv_sel, slv_addr, slv_wdata, slv_rd, slv_wr,
    input  slv_rdata, slv_ack
  );

  modport slave (
    input  slv_sel, slv_addr, slv_wdata, slv_rd, slv_wr,
    output slv_rdata, slv_ack
  );
endinterface

// File: rtl/fsmc_slave_dispatcher.sv
// -----------------------------------------------------------------------------
// fsmc_slave_dispatcher
// Shares the FSMC data path between up to eight slave register blocks. On each
// access window (en_cs rise) it decodes the chip-select index, prefetches the
// read data into module_out, forwards captured write data as a one-cycle
// write strobe and reports cs_state back to fsmc_interface.
//
// Optional feature: define FSMC_DISP_TIMEOUT_EN to add an ack timeout counter
// (TIMEOUT cycles; on expiry err is set and ERR_DATA is returned on reads).
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en_cs           access window from fsmc_interface
//   cs_addr_latch   slave index
//   module_in       address at window start, write data on data_strobe
//   data_strobe     1-cycle pulse: write data captured
//   cs_state        selected slave populated and window open
//   module_out      read data toward fsmc_interface
//   busy            FSM not in IDLE
//   err             sticky: dropped window or (optionally) ack timeout
//   state_dbg       current FSM state (0 IDLE, 1 PREFETCH, 2 HOLD, 3 WRITE)
//   bus             slave-side request/ack bus (master modport)
// -----------------------------------------------------------------------------
module fsmc_slave_dispatcher #(
  parameter int          NSLV     = 8,
  parameter logic [7:0]  SLV_MASK = 8'hFF,
  parameter int          ADDR_W   = 15,
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_cs,
  input  logic [2:0]  cs_addr_latch,
  input  logic [15:0] module_in,
  input  logic        data_strobe,
  output logic        cs_state,
  output logic [15:0] module_out,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg,
  fsmc_slave_dispatcher_if.master bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREFETCH = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_WRITE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              en_cs_q;
  logic [2:0]        idx_q, idx_d;
  logic              mapped_q, mapped_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              cs_state_q, cs_state_d;
  logic [15:0]       mout_q, mout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              pend_wr_q, pend_wr_d;
  logic              prise_q, prise_d;
  logic [2:0]        pidx_q, pidx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              err_q, err_d;

  logic              rise;
  logic              ack_hit;
  logic [15:0]       rdata_sel;
  logic              tmo;
  logic              start;
  logic [2:0]        start_idx;
  logic [ADDR_W-1:0] start_addr;

  logic unused_in;
  assign unused_in = ^module_in;

  function automatic logic is_mapped(input logic [2:0] idx);
    return (int'(idx) < NSLV) && SLV_MASK[idx];
  endfunction

  assign rise = en_cs && !en_cs_q;

  // Only the currently selected slave's ack and read data are observed.
  always_comb begin
    ack_hit   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == 3'(i)) begin
        ack_hit   = bus.slv_ack[i];
        rdata_sel = bus.slv_rdata[16*i +: 16];
      end
    end
  end

`ifdef FSMC_DISP_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       waiting;

  assign waiting = (state_q == S_PREFETCH) || (state_q == S_WRITE);
  // Fires on the TIMEOUT-th edge spent waiting without an ack.
  assign tmo     = waiting && !ack_hit && (cnt_q == 8'(TIMEOUT - 1));

  // Restart from zero whenever a wait state is entered or left.
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 8'(TIMEOUT)};
  assign tmo        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mapped_d   = mapped_q;
    sel_d      = sel_q;
    cs_state_d = cs_state_q;
    mout_d     = mout_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    pend_wr_d  = pend_wr_q;
    prise_d    = prise_q;
    pidx_d     = pidx_q;
    paddr_d    = paddr_q;
    err_d      = err_q;
    start      = 1'b0;
    start_idx  = cs_addr_latch;
    start_addr = module_in[ADDR_W-1:0];

    // A window opening while busy is parked in a 1-deep slot; a second one
    // is lost and flagged.
    if ((state_q != S_IDLE) && rise) begin
      if (prise_q) begin
        err_d = 1'b1;
      end else begin
        prise_d = 1'b1;
        pidx_d  = cs_addr_latch;
        paddr_d = module_in[ADDR_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (prise_q) begin
          start      = 1'b1;
          start_idx  = pidx_q;
          start_addr = paddr_q;
          prise_d    = 1'b0;
          if (rise) begin
            prise_d = 1'b1;
            pidx_d  = cs_addr_latch;
            paddr_d = module_in[ADDR_W-1:0];
          end
        end else if (rise) begin
          start = 1'b1;
        end

        if (start) begin
          idx_d     = start_idx;
          pend_wr_d = 1'b0;
          if (is_mapped(start_idx)) begin
            mapped_d   = 1'b1;
            addr_d     = start_addr;
            for (int i = 0; i < NSLV; i++) sel_d[i] = (start_idx == 3'(i));
            cs_state_d = 1'b1;
            rd_d       = 1'b1;
            state_d    = S_PREFETCH;
          end else begin
            mapped_d   = 1'b0;
            sel_d      = '0;
            cs_state_d = 1'b0;
            state_d    = S_HOLD;
          end
        end
      end

      S_PREFETCH: begin
        if (data_strobe) begin
          pend_wr_d = 1'b1;
          wdata_d   = module_in;
        end
        if (ack_hit || tmo) begin
          mout_d = ack_hit ? rdata_sel : ERR_DATA;
          if (tmo) err_d = 1'b1;
          // A write captured during the prefetch is issued right after it.
          if (pend_wr_q || data_strobe) begin
            pend_wr_d = 1'b0;
            wr_d      = 1'b1;
            state_d   = S_WRITE;
          end else begin
            state_d   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (data_strobe && mapped_q) begin
          wdata_d = module_in;
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end else if (!en_cs) begin
          sel_d      = '0;
          cs_state_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_WRITE: begin
        if (ack_hit || tmo) begin
          if (tmo) err_d = 1'b1;
          sel_d      = '0;
          cs_state_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_cs_q    <= 1'b0;
      idx_q      <= '0;
      mapped_q   <= 1'b0;
      sel_q      <= '0;
      cs_state_q <= 1'b0;
      mout_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pend_wr_q  <= 1'b0;
      prise_q    <= 1'b0;
      pidx_q     <= '0;
      paddr_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_cs_q    <= en_cs;
      idx_q      <= idx_d;
      mapped_q   <= mapped_d;
      sel_q      <= sel_d;
      cs_state_q <= cs_state_d;
      mout_q     <= mout_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pend_wr_q  <= pend_wr_d;
      prise_q    <= prise_d;
      pidx_q     <= pidx_d;
      paddr_q    <= paddr_d;
      err_q      <= err_d;
    end
  end

  assign cs_state      = cs_state_q;
  assign module_out    = mout_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign state_dbg     = state_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;
  assign bus.slv_rd    = rd_q;
  assign bus.slv_wr    = wr_q;

endmodule

// File: tb/tb_fsmc_slave_dispatcher.sv
module tb_fsmc_slave_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_cs;
  logic [2:0]  cs_addr_latch;
  logic [15:0] module_in;
  logic        data_strobe;

  logic        cs_state, busy, err;
  logic [15:0] module_out;
  logic [1:0]  state_dbg;
  logic        cs_state2, busy2, err2;
  logic [15:0] module_out2;
  logic [1:0]  state_dbg2;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  fsmc_slave_dispatcher_if #(.NSLV(8), .ADDR_W(15)) bus ();
  fsmc_slave_dispatcher_if #(.NSLV(8), .ADDR_W(15)) bus2 ();

  // Second instance sees the same slave responses but has slave 3 unpopulated.
  assign bus2.slv_rdata = bus.slv_rdata;
  assign bus2.slv_ack   = bus.slv_ack;

  fsmc_slave_dispatcher dut (
    .clk(clk), .reset(reset), .en_cs(en_cs), .cs_addr_latch(cs_addr_latch),
    .module_in(module_in), .data_strobe(data_strobe), .cs_state(cs_state),
    .module_out(module_out), .busy(busy), .err(err), .state_dbg(state_dbg),
    .bus(bus.master)
  );

  fsmc_slave_dispatcher #(.SLV_MASK(8'hF7)) dut2 (
    .clk(clk), .reset(reset), .en_cs(en_cs), .cs_addr_latch(cs_addr_latch),
    .module_in(module_in), .data_strobe(data_strobe), .cs_state(cs_state2),
    .module_out(module_out2), .busy(busy2), .err(err2), .state_dbg(state_dbg2),
    .bus(bus2.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.slv_wr === 1'b1) wr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en_cs         = 1'b0;
    cs_addr_latch = 3'd0;
    module_in     = 16'h0000;
    data_strobe   = 1'b0;
    bus.slv_ack   = 8'h00;
    bus.slv_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (cs_state !== 1'b0) begin bad++; $display("FAIL rst_cs_state got=%0h exp=0", cs_state); end
    total++; if (module_out !== 16'h0) begin bad++; $display("FAIL rst_module_out got=%0h exp=0", module_out); end
    total++; if (busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_busy_err got=%0b%0b exp=00", busy, err); end
    total++; if (bus.slv_sel !== 8'h00) begin bad++; $display("FAIL rst_sel got=%0h exp=0", bus.slv_sel); end
    total++; if (bus.slv_rd !== 1'b0 || bus.slv_wr !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%0b%0b exp=00", bus.slv_rd, bus.slv_wr); end
    total++; if (bus.slv_addr !== 15'h0 || bus.slv_wdata !== 16'h0) begin bad++; $display("FAIL rst_addr_wdata got=%0h/%0h exp=0/0", bus.slv_addr, bus.slv_wdata); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_read();
    apply_reset();
    cs_addr_latch = 3'd3; module_in = 16'h0042; en_cs = 1'b1;
    tick();  // edge T
    module_in = 16'h7FFF;
    total++; if (bus.slv_sel !== 8'h08) begin bad++; $display("FAIL read_sel got=%0h exp=08", bus.slv_sel); end
    total++; if (cs_state !== 1'b1) begin bad++; $display("FAIL read_cs_state got=%0b exp=1", cs_state); end
    total++; if (bus.slv_rd !== 1'b1) begin bad++; $display("FAIL read_rd_pulse got=%0b exp=1", bus.slv_rd); end
    total++; if (bus.slv_addr !== 15'h0042) begin bad++; $display("FAIL read_addr got=%0h exp=0042", bus.slv_addr); end
    // a foreign slave acks first; it must be ignored
    bus.slv_ack = 8'h04; bus.slv_rdata[2*16 +: 16] = 16'h5555;
    tick();  // edge T+1
    total++; if (bus.slv_rd !== 1'b0) begin bad++; $display("FAIL read_rd_single got=%0b exp=0", bus.slv_rd); end
    total++; if (module_out !== 16'h0000 || state_dbg !== 2'd1) begin bad++; $display("FAIL read_foreign_ack got=%0h/%0d exp=0000/1", module_out, state_dbg); end
    bus.slv_ack = 8'h08; bus.slv_rdata[3*16 +: 16] = 16'h1234;
    tick();  // edge A
    bus.slv_ack = 8'h00;
    total++; if (module_out !== 16'h1234) begin bad++; $display("FAIL read_data got=%0h exp=1234", module_out); end
    total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL read_hold got=%0d exp=2", state_dbg); end
    en_cs = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || bus.slv_sel !== 8'h00 || cs_state !== 1'b0) begin bad++; $display("FAIL read_close got=%0b/%0h/%0b exp=0/00/0", busy, bus.slv_sel, cs_state); end
    total++; if (module_out !== 16'h1234) begin bad++; $display("FAIL read_out_held got=%0h exp=1234", module_out); end
  endtask

  task automatic test_write();
    int base;
    apply_reset();
    cs_addr_latch = 3'd0; module_in = 16'h0010; en_cs = 1'b1;
    tick();  // edge T, PREFETCH
    bus.slv_ack = 8'h01; bus.slv_rdata[15:0] = 16'hA5A5;
    tick();  // zero-wait ack -> HOLD
    bus.slv_ack = 8'h00;
    total++; if (state_dbg !== 2'd2 || module_out !== 16'hA5A5) begin bad++; $display("FAIL wr_zero_wait got=%0d/%0h exp=2/a5a5", state_dbg, module_out); end
    base = wr_cnt;
    module_in = 16'hBEEF; data_strobe = 1'b1;
    tick();  // edge D
    data_strobe = 1'b0; module_in = 16'h0000;
    total++; if (bus.slv_wdata !== 16'hBEEF || bus.slv_wr !== 1'b1) begin bad++; $display("FAIL wr_strobe got=%0h/%0b exp=beef/1", bus.slv_wdata, bus.slv_wr); end
    total++; if (bus.slv_addr !== 15'h0010) begin bad++; $display("FAIL wr_addr got=%0h exp=0010", bus.slv_addr); end
    tick();
    total++; if (bus.slv_wr !== 1'b0 || state_dbg !== 2'd3) begin bad++; $display("FAIL wr_single got=%0b/%0d exp=0/3", bus.slv_wr, state_dbg); end
    bus.slv_ack = 8'h01;
    tick();  // ack edge
    bus.slv_ack = 8'h00;
    total++; if (busy !== 1'b0 || cs_state !== 1'b0 || bus.slv_sel !== 8'h00) begin bad++; $display("FAIL wr_done got=%0b/%0b/%0h exp=0/0/00", busy, cs_state, bus.slv_sel); end
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wr_cnt - base); end
    en_cs = 1'b0;
    tick();
  endtask

  task automatic test_unmapped();
    apply_reset();
    cs_addr_latch = 3'd1; module_in = 16'h0005; en_cs = 1'b1;
    tick();
    bus.slv_ack = 8'h02; bus.slv_rdata[1*16 +: 16] = 16'h4321;
    tick();
    bus.slv_ack = 8'h00; en_cs = 1'b0;
    tick();
    total++; if (module_out2 !== 16'h4321 || busy2 !== 1'b0) begin bad++; $display("FAIL unm_setup got=%0h/%0b exp=4321/0", module_out2, busy2); end
    cs_addr_latch = 3'd3; module_in = 16'h0077; en_cs = 1'b1;
    tick();
    total++; if (cs_state2 !== 1'b0 || bus2.slv_sel !== 8'h00 || bus2.slv_rd !== 1'b0) begin bad++; $display("FAIL unm_select got=%0b/%0h/%0b exp=0/00/0", cs_state2, bus2.slv_sel, bus2.slv_rd); end
    total++; if (state_dbg2 !== 2'd2) begin bad++; $display("FAIL unm_hold got=%0d exp=2", state_dbg2); end
    module_in = 16'h1111; data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0;
    total++; if (bus2.slv_wr !== 1'b0 || bus2.slv_wdata !== 16'h0000) begin bad++; $display("FAIL unm_write got=%0b/%0h exp=0/0000", bus2.slv_wr, bus2.slv_wdata); end
    en_cs = 1'b0;
    tick();
    total++; if (busy2 !== 1'b0 || module_out2 !== 16'h4321 || err2 !== 1'b0) begin bad++; $display("FAIL unm_close got=%0b/%0h/%0b exp=0/4321/0", busy2, module_out2, err2); end
  endtask

  task automatic test_prefetch_write();
    int base;
    apply_reset();
    base = wr_cnt;
    cs_addr_latch = 3'd5; module_in = 16'h0100; en_cs = 1'b1;
    tick();
    module_in = 16'hCAFE; data_strobe = 1'b1;
    tick();
    data_strobe = 1'b0; module_in = 16'h0000;
    total++; if (bus.slv_wr !== 1'b0 || state_dbg !== 2'd1) begin bad++; $display("FAIL pf_pending got=%0b/%0d exp=0/1", bus.slv_wr, state_dbg); end
    bus.slv_rdata[5*16 +: 16] = 16'h7777; bus.slv_ack = 8'h20;
    tick();  // read ack
    total++; if (module_out !== 16'h7777) begin bad++; $display("FAIL pf_read_data got=%0h exp=7777", module_out); end
    total++; if (bus.slv_wr !== 1'b1 || bus.slv_wdata !== 16'hCAFE || state_dbg !== 2'd3) begin bad++; $display("FAIL pf_write got=%0b/%0h/%0d exp=1/cafe/3", bus.slv_wr, bus.slv_wdata, state_dbg); end
    tick();  // write ack (ack held)
    bus.slv_ack = 8'h00;
    total++; if (bus.slv_wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL pf_done got=%0b/%0b exp=0/0", bus.slv_wr, busy); end
    en_cs = 1'b0;
    tick();
    total++; if (wr_cnt - base !== 1 || err !== 1'b0) begin bad++; $display("FAIL pf_wr_count got=%0d/%0b exp=1/0", wr_cnt - base, err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cs_addr_latch = 3'd2; module_in = 16'h0033; en_cs = 1'b1;
    tick();
    total++; if (bus.slv_rd !== 1'b1) begin bad++; $display("FAIL rm_rd got=%0b exp=1", bus.slv_rd); end
    reset = 1'b1; en_cs = 1'b0;
    tick();
    reset = 1'b0;
    total++; if (bus.slv_sel !== 8'h00 || cs_state !== 1'b0 || busy !== 1'b0 || bus.slv_addr !== 15'h0) begin bad++; $display("FAIL rm_clear got=%0h/%0b/%0b/%0h exp=00/0/0/0", bus.slv_sel, cs_state, busy, bus.slv_addr); end
    bus.slv_ack = 8'h04; bus.slv_rdata[2*16 +: 16] = 16'h9999;
    tick();
    bus.slv_ack = 8'h00;
    total++; if (module_out !== 16'h0000 || busy !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL rm_late_ack got=%0h/%0b/%0d exp=0000/0/0", module_out, busy, state_dbg); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    cs_addr_latch = 3'd1; module_in = 16'h0100; en_cs = 1'b1;
    tick();
    en_cs = 1'b0;
    tick();
    cs_addr_latch = 3'd2; module_in = 16'h0200; en_cs = 1'b1;
    tick();  // parked
    en_cs = 1'b0;
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_parked_err got=%0b exp=0", err); end
    cs_addr_latch = 3'd6; module_in = 16'h0600; en_cs = 1'b1;
    tick();  // dropped
    total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL b2b_drop got=%0b/%0b exp=1/1", err, busy); end
    en_cs = 1'b0; bus.slv_ack = 8'h02; bus.slv_rdata[1*16 +: 16] = 16'h1111;
    tick();
    bus.slv_ack = 8'h00;
    total++; if (module_out !== 16'h1111 || state_dbg !== 2'd2) begin bad++; $display("FAIL b2b_first got=%0h/%0d exp=1111/2", module_out, state_dbg); end
    tick();
    total++; if (busy !== 1'b0 || bus.slv_sel !== 8'h00) begin bad++; $display("FAIL b2b_idle got=%0b/%0h exp=0/00", busy, bus.slv_sel); end
    tick();
    total++; if (bus.slv_sel !== 8'h04 || bus.slv_rd !== 1'b1 || bus.slv_addr !== 15'h0200) begin bad++; $display("FAIL b2b_pending got=%0h/%0b/%0h exp=04/1/0200", bus.slv_sel, bus.slv_rd, bus.slv_addr); end
    bus.slv_ack = 8'h04; bus.slv_rdata[2*16 +: 16] = 16'h2222;
    tick();
    bus.slv_ack = 8'h00;
    tick();
    total++; if (busy !== 1'b0 || module_out !== 16'h2222 || err !== 1'b1) begin bad++; $display("FAIL b2b_end got=%0b/%0h/%0b exp=0/2222/1", busy, module_out, err); end
  endtask

`ifdef FSMC_DISP_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    cs_addr_latch = 3'd4; module_in = 16'h0004; en_cs = 1'b1;
    tick();
    en_cs = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++; if (busy !== 1'b1 || err !== 1'b0 || module_out !== 16'h0000) begin bad++; $display("FAIL to_before got=%0b/%0b/%0h exp=1/0/0000", busy, err, module_out); end
    tick();
    total++; if (module_out !== 16'hDEAD || err !== 1'b1) begin bad++; $display("FAIL to_fire got=%0h/%0b exp=dead/1", module_out, err); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0b exp=0", busy); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_prefetch_write();
    test_reset_mid();
    test_back_to_back();
`ifdef FSMC_DISP_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
